// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and sizing helpers for the AES output interface.
package aes_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   function automatic int words_of(input int word_w);
      return AES_BLK_W / word_w;
   endfunction

   function automatic int cnt_w_of(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit circular block buffer; a push while full is accepted only when
// the head block is popped in the same cycle, otherwise it is reported as dropped.
module aes_blk_fifo
   import aes_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [AES_BLK_W-1:0] push_data,
   input  logic                 pop,
   output logic [AES_BLK_W-1:0] head_data,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic                 push_drop
);

   logic [AES_BLK_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 pop_ok;
   logic                 push_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign push_drop = push && !push_ok;

endmodule

// File: rtl/aes_output_interface.sv
// Buffers ciphertext blocks and streams them MSW-first on a valid/ready port.
// Define AES_OUT_PARITY_EN to add the per-byte out_par output.
module aes_output_interface
   import aes_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ct_valid,
   input  logic [AES_BLK_W-1:0] cipher_text,
   output logic                 space_avail,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_W-1:0]    out_data,
   output logic                 out_last,
   output logic                 overflow,
   input  logic                 clr_ovf
`ifdef AES_OUT_PARITY_EN
   ,
   output logic [WORD_W/8-1:0]  out_par
`endif
);

   localparam int WORDS  = words_of(WORD_W);
   localparam int WCNT_W = cnt_w_of(WORDS);
   localparam int FCNT_W = $clog2(DEPTH + 1);

   logic [AES_BLK_W-1:0] head_data;
   logic [AES_BLK_W-1:0] head_shift;
   logic [FCNT_W-1:0]    fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push_drop;
   logic                 blk_pop;
   logic                 push_acc;
   logic                 hs;
   logic                 last_word;
   logic [WORD_W-1:0]    out_data_c;

   ser_state_e           state_q, state_d;
   logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic                 overflow_q, overflow_d;

   aes_blk_fifo #(
      .DEPTH(DEPTH)
   ) u_blk_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ct_valid),
      .push_data (cipher_text),
      .pop       (blk_pop),
      .head_data (head_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .push_drop (push_drop)
   );

   // A block leaves the buffer only when its final word is handed off.
   always_comb begin
      hs          = out_valid_q && out_ready;
      last_word   = (word_cnt_q == WCNT_W'(WORDS - 1));
      blk_pop     = hs && last_word;
      push_acc    = ct_valid && !push_drop;
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      case (state_q)
         IDLE: begin
            word_cnt_d = '0;
            if (push_acc || !fifo_empty) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (hs) begin
               if (!last_word) begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end else begin
                  word_cnt_d = '0;
                  if (!(fifo_count > FCNT_W'(1)) && !push_acc) begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d    = IDLE;
            word_cnt_d = '0;
         end
      endcase
      out_valid_d = (state_d == SEND);
      out_last_d  = (state_d == SEND) && (word_cnt_d == WCNT_W'(WORDS - 1));
      overflow_d  = push_drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      head_shift = head_data << (int'(word_cnt_q) * WORD_W);
      out_data_c = out_valid_q ? head_shift[AES_BLK_W-1 -: WORD_W] : '0;
   end

`ifdef AES_OUT_PARITY_EN
   always_comb begin
      out_par = '0;
      for (int i = 0; i < WORD_W / 8; i++) begin
         out_par[i] = ^out_data_c[8*i +: 8];
      end
   end
`endif

   assign space_avail = !fifo_full;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_c;
   assign out_last    = out_last_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_aes_output_interface.sv
// Self-checking bench for aes_output_interface: vector table, corner sequences,
// and randomized traffic against a queue-based block/word model.
module tb_aes_output_interface;

   localparam int WW    = 32;
   localparam int DP    = 2;
   localparam int WORDS = 128 / WW;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          clk;
   logic          rst;
   logic          ct_valid;
   logic [127:0]  cipher_text;
   logic          space_avail;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] out_data;
   logic          out_last;
   logic          overflow;
   logic          clr_ovf;
`ifdef AES_OUT_PARITY_EN
   logic [WW/8-1:0] out_par;
`endif

   typedef struct {
      logic          ctv;
      logic [127:0]  ct;
      logic          rdy;
      logic          clr;
      logic          ev;
      logic [WW-1:0] ed;
      logic          el;
      logic          es;
      logic          eo;
   } vec_t;

   vec_t          vecs[15];
   logic [127:0]  mq[$];
   int            widx;
   logic          movf;
   logic [WW-1:0] got[$];
   int            tests_run = 0;
   int            tests_failed = 0;
   logic [127:0]  blk_a, blk_b, blk_c, blk_d;

   aes_output_interface #(
      .WORD_W(WW),
      .DEPTH (DP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ct_valid   (ct_valid),
      .cipher_text(cipher_text),
      .space_avail(space_avail),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
`ifdef AES_OUT_PARITY_EN
      ,
      .out_par    (out_par)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [WW-1:0] word_of(input logic [127:0] blk, input int i);
      return blk[127 - i*WW -: WW];
   endfunction

   function automatic logic [WW/8-1:0] par_of(input logic [WW-1:0] w);
      logic [WW/8-1:0] p;
      p = '0;
      for (int i = 0; i < WW / 8; i++) p[i] = ^w[8*i +: 8];
      return p;
   endfunction

   function automatic vec_t mk(input logic ctv, input logic [127:0] ct, input logic rdy,
                               input logic ev, input logic [WW-1:0] ed, input logic el);
      vec_t v;
      v.ctv = ctv; v.ct = ct; v.rdy = rdy; v.clr = 1'b0;
      v.ev = ev; v.ed = ed; v.el = el; v.es = 1'b1; v.eo = 1'b0;
      return v;
   endfunction

   task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending blocks in arrival order plus index of the word being offered.
   task automatic model_update(input logic ctv, input logic [127:0] ct, input logic rdy,
                               input logic clr);
      bit hs, ev;
      hs = (mq.size() > 0) && rdy;
      ev = 1'b0;
      if (hs) begin
         if (widx == WORDS - 1) begin
            void'(mq.pop_front());
            widx = 0;
         end else begin
            widx++;
         end
      end
      if (ctv) begin
         if (mq.size() < DP) mq.push_back(ct);
         else ev = 1'b1;
      end
      movf = ev ? 1'b1 : (clr ? 1'b0 : movf);
   endtask

   task automatic check_output();
      logic ev;
      ev = (mq.size() > 0);
      check1("out_valid", out_valid, ev);
      if (ev) begin
         check1("out_data", out_data, word_of(mq[0], widx));
         check1("out_last", out_last, widx == WORDS - 1);
`ifdef AES_OUT_PARITY_EN
         check1("out_par", out_par, par_of(word_of(mq[0], widx)));
      end else begin
         check1("out_par_idle", out_par, '0);
`endif
      end
      check1("space_avail", space_avail, mq.size() < DP);
      check1("overflow", overflow, movf);
   endtask

   task automatic apply_stimulus(input logic ctv, input logic [127:0] ct, input logic rdy,
                                 input logic clr, input bit chk);
      if (chk) check_output();
      if (out_valid === 1'b1 && rdy) got.push_back(out_data);
      ct_valid    = ctv;
      cipher_text = ct;
      out_ready   = rdy;
      clr_ovf     = clr;
      model_update(ctv, ct, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic check_got(input string name, input logic [127:0] b0, input logic [127:0] b1,
                            input logic [127:0] b2, input int nblk);
      logic [127:0] blks[3];
      blks[0] = b0; blks[1] = b1; blks[2] = b2;
      check1({name, "_count"}, got.size(), nblk * WORDS);
      for (int i = 0; i < nblk * WORDS && i < got.size(); i++) begin
         check1($sformatf("%s_w%0d", name, i), got[i], word_of(blks[i / WORDS], i % WORDS));
      end
      got.delete();
   endtask

   initial begin
      rst = 1'b0; ct_valid = 1'b0; cipher_text = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      widx = 0; movf = 1'b0;
      blk_a = {$urandom, $urandom, $urandom, $urandom};
      blk_b = {$urandom, $urandom, $urandom, $urandom};
      blk_c = {$urandom, $urandom, $urandom, $urandom};
      blk_d = {$urandom, $urandom, $urandom, $urandom};

      vecs[0]  = mk(1, FIPS_CT, 1, 0, '0, 0);
      vecs[1]  = mk(0, '0, 1, 1, 32'h69c4e0d8, 0);
      vecs[2]  = mk(0, '0, 1, 1, 32'h6a7b0430, 0);
      vecs[3]  = mk(0, '0, 1, 1, 32'hd8cdb780, 0);
      vecs[4]  = mk(0, '0, 1, 1, 32'h70b4c55a, 1);
      vecs[5]  = mk(0, '0, 1, 0, '0, 0);
      vecs[6]  = mk(1, FIPS_CT, 0, 0, '0, 0);
      vecs[7]  = mk(0, '0, 1, 1, 32'h69c4e0d8, 0);
      vecs[8]  = mk(0, '0, 0, 1, 32'h6a7b0430, 0);
      vecs[9]  = mk(0, '0, 0, 1, 32'h6a7b0430, 0);
      vecs[10] = mk(0, '0, 1, 1, 32'h6a7b0430, 0);
      vecs[11] = mk(0, '0, 1, 1, 32'hd8cdb780, 0);
      vecs[12] = mk(0, '0, 0, 1, 32'h70b4c55a, 1);
      vecs[13] = mk(0, '0, 1, 1, 32'h70b4c55a, 1);
      vecs[14] = mk(0, '0, 0, 0, '0, 0);

      repeat (2) @(posedge clk);
      #1;
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_out_last", out_last, 1'b0);
      check1("rst_out_data", out_data, '0);
      check1("rst_space_avail", space_avail, 1'b1);
      check1("rst_overflow", overflow, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         check1($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
         if (vecs[i].ev) begin
            check1($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
            check1($sformatf("vec%0d_last", i), out_last, vecs[i].el);
         end
         check1($sformatf("vec%0d_space", i), space_avail, vecs[i].es);
         check1($sformatf("vec%0d_ovf", i), overflow, vecs[i].eo);
`ifdef AES_OUT_PARITY_EN
         if (i == 1) check1("par_69c4e0d8", out_par, 4'b0110);
`endif
         apply_stimulus(vecs[i].ctv, vecs[i].ct, vecs[i].rdy, vecs[i].clr, 1'b0);
      end
      check_got("fips_stream", FIPS_CT, FIPS_CT, '0, 2);

      // Fill two slots while stalled, third block must be dropped.
      apply_stimulus(1, blk_a, 0, 0, 1);
      apply_stimulus(1, blk_b, 0, 0, 1);
      check1("full_space_avail", space_avail, 1'b0);
      apply_stimulus(1, blk_c, 0, 0, 1);
      check1("drop_overflow", overflow, 1'b1);
      repeat (10) apply_stimulus(0, '0, 1, 0, 1);
      check_got("fill_stream", blk_a, blk_b, '0, 2);
      apply_stimulus(0, '0, 0, 1, 1);
      check1("ovf_cleared", overflow, 1'b0);

      // Push arriving on the head block's final-word handshake while full.
      apply_stimulus(1, blk_a, 0, 0, 1);
      apply_stimulus(1, blk_b, 0, 0, 1);
      repeat (WORDS - 1) apply_stimulus(0, '0, 1, 0, 1);
      apply_stimulus(1, blk_c, 1, 0, 1);
      check1("pop_push_overflow", overflow, 1'b0);
      repeat (12) apply_stimulus(0, '0, 1, 0, 1);
      check_got("pop_push_stream", blk_a, blk_b, blk_c, 3);

      // Asynchronous reset in the middle of a block.
      apply_stimulus(1, blk_a, 1, 0, 1);
      apply_stimulus(0, '0, 1, 0, 1);
      apply_stimulus(0, '0, 1, 0, 1);
      check1("pre_rst_valid", out_valid, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check1("async_rst_valid", out_valid, 1'b0);
      check1("async_rst_last", out_last, 1'b0);
      check1("async_rst_data", out_data, '0);
      check1("async_rst_space", space_avail, 1'b1);
      check1("async_rst_ovf", overflow, 1'b0);
      mq.delete();
      widx = 0;
      movf = 1'b0;
      got.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) apply_stimulus(0, '0, 1, 0, 1);
      check1("post_rst_no_words", got.size(), 0);
      apply_stimulus(1, blk_d, 1, 0, 1);
      repeat (6) apply_stimulus(0, '0, 1, 0, 1);
      check_got("post_rst_stream", blk_d, '0, '0, 1);

      for (int i = 0; i < 400; i++) begin
         apply_stimulus($urandom_range(0, 9) < 4, {$urandom, $urandom, $urandom, $urandom},
                        $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 1);
      end
      repeat (20) apply_stimulus(0, '0, 1, 0, 1);
      check1("drain_idle", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
